// File: rtl/gray_position_tracker.sv
//------------------------------------------------------------------------------
// Module      : gray_position_tracker
// Description : Synchronises and deglitches a Gray-coded position word,
//               converts it to binary, classifies accepted changes as
//               +1 / -1 steps or illegal jumps, and keeps a signed
//               revolution count across wrap-around.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module gray_position_tracker #(
   parameter int WIDTH         = 4,
   parameter int STABLE_CYCLES = 3,
   parameter int REV_WIDTH     = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   input  logic [WIDTH-1:0]     gray_in,
   input  logic                 clr_err,
   output logic [WIDTH-1:0]     pos_gray,
   output logic [WIDTH-1:0]     pos_bin,
   output logic [REV_WIDTH-1:0] rev_count,
   output logic                 step_valid,
   output logic                 dir,
   output logic                 jump_err,
   output logic                 locked
);

   localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] c_acc_cnt = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] c_sat_cnt = CNT_W'(STABLE_CYCLES);
   localparam logic [WIDTH-1:0] c_pos_max = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] c_pos_one = WIDTH'(1);

   typedef enum logic [0:0] {
      ST_ACQUIRE = 1'b0,
      ST_TRACK   = 1'b1
   } state_t;

   state_t r_state, w_state_nxt;

   logic [WIDTH-1:0]     r_s1, r_sync, r_cand;
   logic                 r_s1_vld, r_sync_vld, r_cand_vld;
   logic [CNT_W-1:0]     r_cnt;
   logic [WIDTH-1:0]     r_pos_gray, r_pos_bin;
   logic [REV_WIDTH-1:0] r_rev;
   logic                 r_step, r_dir, r_err;

   logic                 w_accept;
   logic [WIDTH-1:0]     w_cand_bin, w_delta;
   logic [WIDTH-1:0]     w_pos_gray_nxt, w_pos_bin_nxt;
   logic [REV_WIDTH-1:0] w_rev_nxt;
   logic                 w_step_nxt, w_dir_nxt, w_err_set, w_err_nxt;

   function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
      logic [WIDTH-1:0] b;
      b[WIDTH-1] = g[WIDTH-1];
      for (int i = WIDTH - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   // Two-flop synchroniser plus glitch filter. The valid bits keep the
   // zeroed reset contents of the pipeline from being mistaken for a sample,
   // so power-up acquisition takes the same time as any other change.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1       <= '0;
         r_sync     <= '0;
         r_s1_vld   <= 1'b0;
         r_sync_vld <= 1'b0;
         r_cand     <= '0;
         r_cand_vld <= 1'b0;
         r_cnt      <= '0;
      end else begin
         r_s1       <= gray_in;
         r_s1_vld   <= 1'b1;
         r_sync     <= r_s1;
         r_sync_vld <= r_s1_vld;
         if (r_sync_vld) begin
            if (!r_cand_vld || (r_sync != r_cand)) begin
               r_cand     <= r_sync;
               r_cand_vld <= 1'b1;
               r_cnt      <= '0;
            end else if (r_cnt != c_sat_cnt) begin
               r_cnt <= r_cnt + CNT_W'(1);
            end
         end
      end
   end

   // Fires exactly once per stable value; saturation keeps it from repeating.
   assign w_accept   = r_sync_vld && r_cand_vld && (r_sync == r_cand) && (r_cnt == c_acc_cnt);
   assign w_cand_bin = gray2bin(r_cand);
   assign w_delta    = w_cand_bin - r_pos_bin;

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_ACQUIRE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and datapath updates: step classification and revolution count.
   always_comb begin
      w_state_nxt    = r_state;
      w_pos_gray_nxt = r_pos_gray;
      w_pos_bin_nxt  = r_pos_bin;
      w_rev_nxt      = r_rev;
      w_step_nxt     = 1'b0;
      w_dir_nxt      = r_dir;
      w_err_set      = 1'b0;
      if (!en) begin
         w_state_nxt = ST_ACQUIRE;
      end else begin
         case (r_state)
            ST_ACQUIRE: begin
               if (w_accept) begin
                  w_pos_gray_nxt = r_cand;
                  w_pos_bin_nxt  = w_cand_bin;
                  w_state_nxt    = ST_TRACK;
               end
            end
            ST_TRACK: begin
               if (w_accept && (r_cand != r_pos_gray)) begin
                  w_pos_gray_nxt = r_cand;
                  w_pos_bin_nxt  = w_cand_bin;
                  if (w_delta == c_pos_one) begin
                     w_step_nxt = 1'b1;
                     w_dir_nxt  = 1'b1;
                     if (r_pos_bin == c_pos_max) begin
                        w_rev_nxt = r_rev + REV_WIDTH'(1);
                     end
                  end else if (w_delta == c_pos_max) begin
                     w_step_nxt = 1'b1;
                     w_dir_nxt  = 1'b0;
                     if (r_pos_bin == '0) begin
                        w_rev_nxt = r_rev - REV_WIDTH'(1);
                     end
                  end else begin
                     w_err_set = 1'b1;
                  end
               end
            end
            default: w_state_nxt = ST_ACQUIRE;
         endcase
      end
      // A new jump in the same cycle as clr_err keeps the flag set.
      w_err_nxt = w_err_set | (r_err & ~clr_err);
   end

   // Output / position registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pos_gray <= '0;
         r_pos_bin  <= '0;
         r_rev      <= '0;
         r_step     <= 1'b0;
         r_dir      <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_pos_gray <= w_pos_gray_nxt;
         r_pos_bin  <= w_pos_bin_nxt;
         r_rev      <= w_rev_nxt;
         r_step     <= w_step_nxt;
         r_dir      <= w_dir_nxt;
         r_err      <= w_err_nxt;
      end
   end

   assign pos_gray   = r_pos_gray;
   assign pos_bin    = r_pos_bin;
   assign rev_count  = r_rev;
   assign step_valid = r_step;
   assign dir        = r_dir;
   assign jump_err   = r_err;
   assign locked     = (r_state == ST_TRACK);

endmodule

`default_nettype wire

// File: tb/tb_gray_position_tracker.sv
//------------------------------------------------------------------------------
// Module      : tb_gray_position_tracker
// Description : Directed, table-driven self-checking bench for
//               gray_position_tracker (default parameters).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_gray_position_tracker;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic [3:0] gray_in;
   logic       clr_err;
   logic [3:0] pos_gray;
   logic [3:0] pos_bin;
   logic [7:0] rev_count;
   logic       step_valid;
   logic       dir;
   logic       jump_err;
   logic       locked;

   int n_tests = 0;
   int n_fail  = 0;

   gray_position_tracker #(
      .WIDTH         (4),
      .STABLE_CYCLES (3),
      .REV_WIDTH     (8)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .gray_in    (gray_in),
      .clr_err    (clr_err),
      .pos_gray   (pos_gray),
      .pos_bin    (pos_bin),
      .rev_count  (rev_count),
      .step_valid (step_valid),
      .dir        (dir),
      .jump_err   (jump_err),
      .locked     (locked)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] gray;
      logic [3:0] bin;
      logic       dir;
      logic [7:0] rev;
   } vec_t;

   vec_t tbl[24];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Advance one edge and sample 1 time unit later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Apply a gray value, hold it n edges, count step pulses and record dir at the pulse.
   task automatic hold(input logic [3:0] g, input int n, output int steps, output logic d);
      gray_in = g;
      steps   = 0;
      d       = dir;
      repeat (n) begin
         tick();
         if (step_valid) begin
            steps++;
            d = dir;
         end
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " pos_gray"},   32'(pos_gray),   32'd0);
      chk({tag, " pos_bin"},    32'(pos_bin),    32'd0);
      chk({tag, " rev_count"},  32'(rev_count),  32'd0);
      chk({tag, " step_valid"}, 32'(step_valid), 32'd0);
      chk({tag, " dir"},        32'(dir),        32'd0);
      chk({tag, " jump_err"},   32'(jump_err),   32'd0);
      chk({tag, " locked"},     32'(locked),     32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int   steps;
      logic d;

      tbl[0]  = '{4'b0001, 4'd1,  1'b1, 8'd0};
      tbl[1]  = '{4'b0011, 4'd2,  1'b1, 8'd0};
      tbl[2]  = '{4'b0010, 4'd3,  1'b1, 8'd0};
      tbl[3]  = '{4'b0110, 4'd4,  1'b1, 8'd0};
      tbl[4]  = '{4'b0111, 4'd5,  1'b1, 8'd0};
      tbl[5]  = '{4'b0101, 4'd6,  1'b1, 8'd0};
      tbl[6]  = '{4'b0100, 4'd7,  1'b1, 8'd0};
      tbl[7]  = '{4'b1100, 4'd8,  1'b1, 8'd0};
      tbl[8]  = '{4'b1101, 4'd9,  1'b1, 8'd0};
      tbl[9]  = '{4'b1111, 4'd10, 1'b1, 8'd0};
      tbl[10] = '{4'b1110, 4'd11, 1'b1, 8'd0};
      tbl[11] = '{4'b1010, 4'd12, 1'b1, 8'd0};
      tbl[12] = '{4'b1011, 4'd13, 1'b1, 8'd0};
      tbl[13] = '{4'b1001, 4'd14, 1'b1, 8'd0};
      tbl[14] = '{4'b1000, 4'd15, 1'b1, 8'd0};
      tbl[15] = '{4'b0000, 4'd0,  1'b1, 8'd1};
      tbl[16] = '{4'b1000, 4'd15, 1'b0, 8'd0};
      tbl[17] = '{4'b1001, 4'd14, 1'b0, 8'd0};
      tbl[18] = '{4'b1000, 4'd15, 1'b1, 8'd0};
      tbl[19] = '{4'b0000, 4'd0,  1'b1, 8'd1};
      tbl[20] = '{4'b0001, 4'd1,  1'b1, 8'd1};
      tbl[21] = '{4'b0000, 4'd0,  1'b0, 8'd1};
      tbl[22] = '{4'b1000, 4'd15, 1'b0, 8'd0};
      tbl[23] = '{4'b0000, 4'd0,  1'b1, 8'd1};

      // Power-up reset and acquisition of a held 0000
      rst_n   = 1'b0;
      en      = 1'b1;
      gray_in = 4'b0000;
      clr_err = 1'b0;
      #2;
      chk_all_zero("reset");
      repeat (2) tick();
      rst_n = 1'b1;
      steps = 0;
      repeat (5) begin
         tick();
         if (step_valid) steps++;
      end
      tick();
      if (step_valid) steps++;
      chk("acq locked@6",  32'(locked),   32'd1);
      chk("acq pos_bin",   32'(pos_bin),  32'd0);
      chk("acq jump_err",  32'(jump_err), 32'd0);
      hold(4'b0000, 5, steps, d);
      chk("acq no step",   32'(steps),    32'd0);

      // Stepping through the table: every row is a legal single step
      for (int i = 0; i < 24; i++) begin
         hold(tbl[i].gray, 10, steps, d);
         chk($sformatf("row%0d steps", i),    32'(steps),     32'd1);
         chk($sformatf("row%0d dir", i),      32'(d),         32'(tbl[i].dir));
         chk($sformatf("row%0d pos_bin", i),  32'(pos_bin),   32'(tbl[i].bin));
         chk($sformatf("row%0d pos_gray", i), 32'(pos_gray),  32'(tbl[i].gray));
         chk($sformatf("row%0d rev", i),      32'(rev_count), 32'(tbl[i].rev));
         chk($sformatf("row%0d jump_err", i), 32'(jump_err),  32'd0);
      end

      // Glitch shorter than the filter window is rejected
      hold(4'b0001, 2, steps, d);
      chk("glitch steps a", 32'(steps), 32'd0);
      hold(4'b0000, 10, steps, d);
      chk("glitch steps b", 32'(steps),   32'd0);
      chk("glitch pos_bin", 32'(pos_bin), 32'd0);

      // Illegal jump 0 -> 4
      hold(4'b0110, 10, steps, d);
      chk("jump steps",    32'(steps),     32'd0);
      chk("jump pos_bin",  32'(pos_bin),   32'd4);
      chk("jump err",      32'(jump_err),  32'd1);
      chk("jump rev",      32'(rev_count), 32'd1);
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      chk("clr_err", 32'(jump_err), 32'd0);

      // New jump 4 -> 2 landing on the same edge as clr_err: set wins
      hold(4'b0011, 5, steps, d);
      chk("setwin pos@5",  32'(pos_bin), 32'd4);
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      chk("setwin pos@6",  32'(pos_bin),  32'd2);
      chk("setwin err",    32'(jump_err), 32'd1);
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      chk("setwin clr",    32'(jump_err), 32'd0);

      // Disable: position held, then silent reload after re-enable
      en = 1'b0;
      tick();
      chk("dis locked", 32'(locked), 32'd0);
      hold(4'b0010, 10, steps, d);
      chk("dis steps",   32'(steps),     32'd0);
      chk("dis pos_bin", 32'(pos_bin),   32'd2);
      chk("dis rev",     32'(rev_count), 32'd1);
      en = 1'b1;
      hold(4'b0110, 10, steps, d);
      chk("reen steps",   32'(steps),    32'd0);
      chk("reen pos_bin", 32'(pos_bin),  32'd4);
      chk("reen locked",  32'(locked),   32'd1);
      chk("reen err",     32'(jump_err), 32'd0);
      chk("reen dir",     32'(dir),      32'd1);

      // Asynchronous reset mid-operation, then reacquire 0111
      hold(4'b0111, 3, steps, d);
      #3;
      rst_n = 1'b0;
      #1;
      chk_all_zero("midrst");
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (6) tick();
      chk("reacq locked",   32'(locked),    32'd1);
      chk("reacq pos_gray", 32'(pos_gray),  32'd7);
      chk("reacq pos_bin",  32'(pos_bin),   32'd5);
      chk("reacq rev",      32'(rev_count), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
